// File: rtl/dualshock_responder.sv
`timescale 1ns/1ps
// DualShock-style SPI mode 3 controller responder running entirely in the PCLK domain.
// Answers the 0x01/0x42 poll with ID, 0x5A marker and snapshotted button/stick data.
module dualshock_responder #(
    parameter int unsigned ACK_DELAY = 4,
    parameter int unsigned ACK_WIDTH = 8
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        SPISCLK,
    input  logic        SPISS,
    input  logic        SPISDI,
    output logic        SPISDO,
    output logic        ACK_N,
    input  logic [15:0] BUTTONS,
    input  logic [7:0]  RX,
    input  logic [7:0]  RY,
    input  logic [7:0]  LX,
    input  logic [7:0]  LY,
    input  logic        ANALOG,
    output logic [7:0]  LAST_CMD,
    output logic        FRAME_DONE,
    output logic        CMD_ERR
);

    localparam logic [7:0] AckOn  = 8'(ACK_DELAY);
    localparam logic [7:0] AckOff = 8'(ACK_DELAY + ACK_WIDTH);

    typedef enum logic [2:0] {StIdle, StHeader, StCmd, StMark, StData, StIgnore} state_t;

    logic [1:0]  sclk_sync, ss_sync, sdi_sync;
    logic        sclk_prev, ss_prev;
    state_t      state;
    logic [2:0]  bit_cnt;
    logic [3:0]  byte_cnt;
    logic [7:0]  rx_sr, tx_sr;
    logic [15:0] snap_btn;
    logic [7:0]  snap_rx, snap_ry, snap_lx, snap_ly;
    logic        snap_analog;
    logic        ack_busy;
    logic [7:0]  ack_cnt;

    logic        sclk_rise, sclk_fall, ss_rise, ss_fall, byte_done;
    logic [7:0]  rx_byte, id_byte, data_tx, nxt_tx;
    logic [3:0]  next_idx, last_idx;
    state_t      nxt_state;
    logic        fire_ack, fire_err, fire_done;

    always_comb begin
        sclk_rise = sclk_sync[1] & ~sclk_prev;
        sclk_fall = ~sclk_sync[1] & sclk_prev;
        ss_rise   = ss_sync[1] & ~ss_prev;
        ss_fall   = ~ss_sync[1] & ss_prev;
        rx_byte   = {sdi_sync[1], rx_sr[7:1]};
        byte_done = (state != StIdle) && sclk_rise && (bit_cnt == 3'd7);
        id_byte   = snap_analog ? 8'h73 : 8'h41;
        last_idx  = snap_analog ? 4'd8 : 4'd4;
        next_idx  = byte_cnt + 4'd1;

        case (next_idx)
            4'd3:    data_tx = snap_btn[7:0];
            4'd4:    data_tx = snap_btn[15:8];
            4'd5:    data_tx = snap_rx;
            4'd6:    data_tx = snap_ry;
            4'd7:    data_tx = snap_lx;
            4'd8:    data_tx = snap_ly;
            default: data_tx = 8'hFF;
        endcase

        // Decision taken when the byte in flight completes.
        nxt_state = state;
        nxt_tx    = 8'hFF;
        fire_ack  = 1'b0;
        fire_err  = 1'b0;
        fire_done = 1'b0;
        unique case (state)
            StHeader: begin
                if (rx_byte == 8'h01) begin
                    nxt_state = StCmd;
                    nxt_tx    = id_byte;
                    fire_ack  = 1'b1;
                end else begin
                    nxt_state = StIgnore;
                    fire_err  = 1'b1;
                end
            end
            StCmd: begin
                if (rx_byte == 8'h42) begin
                    nxt_state = StMark;
                    nxt_tx    = 8'h5A;
                    fire_ack  = 1'b1;
                end else begin
                    nxt_state = StIgnore;
                    fire_err  = 1'b1;
                end
            end
            StMark: begin
                nxt_state = StData;
                nxt_tx    = data_tx;
                fire_ack  = 1'b1;
            end
            StData: begin
                if (byte_cnt >= last_idx) begin
                    nxt_state = StIgnore;
                    fire_done = 1'b1;
                end else begin
                    nxt_tx   = data_tx;
                    fire_ack = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sclk_sync   <= 2'b11;
            ss_sync     <= 2'b11;
            sdi_sync    <= 2'b00;
            sclk_prev   <= 1'b1;
            ss_prev     <= 1'b1;
            state       <= StIdle;
            bit_cnt     <= 3'd0;
            byte_cnt    <= 4'd0;
            rx_sr       <= 8'h00;
            tx_sr       <= 8'hFF;
            snap_btn    <= 16'hFFFF;
            snap_rx     <= 8'h00;
            snap_ry     <= 8'h00;
            snap_lx     <= 8'h00;
            snap_ly     <= 8'h00;
            snap_analog <= 1'b0;
            ack_busy    <= 1'b0;
            ack_cnt     <= 8'd0;
            SPISDO      <= 1'b1;
            ACK_N       <= 1'b1;
            LAST_CMD    <= 8'h00;
            FRAME_DONE  <= 1'b0;
            CMD_ERR     <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[0], SPISCLK};
            ss_sync    <= {ss_sync[0], SPISS};
            sdi_sync   <= {sdi_sync[0], SPISDI};
            sclk_prev  <= sclk_sync[1];
            ss_prev    <= ss_sync[1];
            FRAME_DONE <= 1'b0;
            CMD_ERR    <= 1'b0;

            if (ack_busy) begin
                ack_cnt <= ack_cnt + 8'd1;
                if (ack_cnt == AckOn) ACK_N <= 1'b0;
                if (ack_cnt == AckOff) begin
                    ACK_N    <= 1'b1;
                    ack_busy <= 1'b0;
                end
            end

            if (ss_rise) begin
                state    <= StIdle;
                bit_cnt  <= 3'd0;
                byte_cnt <= 4'd0;
                SPISDO   <= 1'b1;
                ACK_N    <= 1'b1;
                ack_busy <= 1'b0;
            end else if (ss_fall) begin
                state       <= StHeader;
                bit_cnt     <= 3'd0;
                byte_cnt    <= 4'd0;
                tx_sr       <= 8'hFF;
                SPISDO      <= 1'b1;
                ACK_N       <= 1'b1;
                ack_busy    <= 1'b0;
                snap_btn    <= BUTTONS;
                snap_rx     <= RX;
                snap_ry     <= RY;
                snap_lx     <= LX;
                snap_ly     <= LY;
                snap_analog <= ANALOG;
            end else if (state != StIdle) begin
                if (sclk_fall) SPISDO <= (state == StIgnore) ? 1'b1 : tx_sr[bit_cnt];
                if (sclk_rise) begin
                    rx_sr   <= rx_byte;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    if (byte_cnt != 4'hF) byte_cnt <= next_idx;
                    if (state == StCmd) LAST_CMD <= rx_byte;
                    state      <= nxt_state;
                    tx_sr      <= nxt_tx;
                    SPISDO     <= nxt_tx[0];
                    CMD_ERR    <= fire_err;
                    FRAME_DONE <= fire_done;
                    // A new acknowledged byte restarts any ACK still in progress.
                    if (fire_ack) begin
                        ack_busy <= 1'b1;
                        ack_cnt  <= 8'd1;
                        ACK_N    <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dualshock_responder.sv
`timescale 1ns/1ps
// Randomized and directed frame-level bench for dualshock_responder; the model predicts
// each reply byte, ACK count/width, FRAME_DONE, CMD_ERR and LAST_CMD from the poll rules.
module tb_dualshock_responder;

    localparam int unsigned AckDelay = 4;
    localparam int unsigned AckWidth = 8;

    logic        PCLK, PRESET, SPISCLK, SPISS, SPISDI, SPISDO, ACK_N, ANALOG;
    logic        FRAME_DONE, CMD_ERR;
    logic [15:0] BUTTONS;
    logic [7:0]  RX, RY, LX, LY, LAST_CMD;

    int   n_checks = 0;
    int   n_errors = 0;
    int   ack_seen = 0;
    int   fd_seen  = 0;
    int   err_seen = 0;
    bit   skip_width = 0;
    bit   ack_armed  = 0;
    time  ack_t0;
    logic [7:0] model_last_cmd = 8'h00;

    dualshock_responder #(
        .ACK_DELAY(AckDelay),
        .ACK_WIDTH(AckWidth)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .SPISCLK   (SPISCLK),
        .SPISS     (SPISS),
        .SPISDI    (SPISDI),
        .SPISDO    (SPISDO),
        .ACK_N     (ACK_N),
        .BUTTONS   (BUTTONS),
        .RX        (RX),
        .RY        (RY),
        .LX        (LX),
        .LY        (LY),
        .ANALOG    (ANALOG),
        .LAST_CMD  (LAST_CMD),
        .FRAME_DONE(FRAME_DONE),
        .CMD_ERR   (CMD_ERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge ACK_N) begin
        if (!PRESET) begin
            ack_seen++;
            ack_t0    = $time;
            ack_armed = 1'b1;
        end
    end

    always @(posedge ACK_N) begin
        if (ack_armed && !skip_width && !PRESET)
            check("ack_width", 32'(($time - ack_t0) / 10), AckWidth);
        ack_armed = 1'b0;
    end

    always @(negedge PCLK) begin
        if (FRAME_DONE === 1'b1) fd_seen++;
        if (CMD_ERR === 1'b1) err_seen++;
    end

    // Master side, mode 3: drive on SCLK low, sample on SCLK rising.
    task automatic send_bits(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
        miso = 8'hFF;
        for (int i = 0; i < nbits; i++) begin
            SPISCLK = 1'b0;
            SPISDI  = mosi[i];
            #80;
            SPISCLK = 1'b1;
            miso[i] = SPISDO;
            #80;
        end
    endtask

    task automatic run_frame(input int nbytes, input logic [7:0] hdr, input logic [7:0] cmd,
                             input int change_at, input logic [15:0] new_btn,
                             input string tag);
        logic [7:0] exp [16];
        logic [7:0] data [6];
        logic [7:0] got, mosi;
        int         len, exp_ack;
        bit         hdr_ok, cmd_ok, valid;
        hdr_ok = (hdr == 8'h01);
        cmd_ok = (cmd == 8'h42);
        valid  = hdr_ok && cmd_ok;
        len    = ANALOG ? 9 : 5;
        data   = '{BUTTONS[7:0], BUTTONS[15:8], RX, RY, LX, LY};
        for (int i = 0; i < 16; i++) exp[i] = 8'hFF;
        if (hdr_ok) exp[1] = ANALOG ? 8'h73 : 8'h41;
        if (valid) begin
            exp[2] = 8'h5A;
            for (int i = 3; i < len; i++) exp[i] = data[i-3];
        end
        exp_ack = valid ? len - 1 : (hdr_ok ? 1 : 0);
        if (hdr_ok) model_last_cmd = cmd;
        ack_seen = 0;
        fd_seen  = 0;
        err_seen = 0;
        SPISS = 1'b0;
        #100;
        for (int b = 0; b < nbytes; b++) begin
            mosi = (b == 0) ? hdr : ((b == 1) ? cmd : 8'h00);
            send_bits(mosi, 8, got);
            check($sformatf("%s byte%0d", tag, b), got, exp[b]);
            if (b == change_at) BUTTONS = new_btn;
            #240;
        end
        SPISS = 1'b1;
        #200;
        check($sformatf("%s ack_count", tag), ack_seen, exp_ack);
        check($sformatf("%s frame_done", tag), fd_seen, valid ? 1 : 0);
        check($sformatf("%s cmd_err", tag), err_seen, valid ? 0 : 1);
        check($sformatf("%s last_cmd", tag), LAST_CMD, model_last_cmd);
        check($sformatf("%s idle_sdo", tag), SPISDO, 1'b1);
        check($sformatf("%s idle_ack", tag), ACK_N, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " sdo"}, SPISDO, 1'b1);
        check({tag, " ack_n"}, ACK_N, 1'b1);
        check({tag, " last_cmd"}, LAST_CMD, 8'h00);
        check({tag, " frame_done"}, FRAME_DONE, 1'b0);
        check({tag, " cmd_err"}, CMD_ERR, 1'b0);
    endtask

    initial begin
        logic [7:0] got, hdr, cmd;
        int         nb;
        PRESET  = 1'b1;
        SPISCLK = 1'b1;
        SPISS   = 1'b1;
        SPISDI  = 1'b0;
        ANALOG  = 1'b0;
        BUTTONS = 16'hFFFF;
        RX = 8'h00; RY = 8'h00; LX = 8'h00; LY = 8'h00;
        repeat (3) @(negedge PCLK);
        check_reset_outputs("reset");
        PRESET = 1'b0;
        #100;

        // Digital and analog polls
        ANALOG = 1'b0; BUTTONS = 16'hFFF7;
        run_frame(5, 8'h01, 8'h42, -1, 16'h0, "digital");
        ANALOG = 1'b1; BUTTONS = 16'hFFFF;
        RX = 8'h80; RY = 8'h7F; LX = 8'h00; LY = 8'hFF;
        run_frame(9, 8'h01, 8'h42, -1, 16'h0, "analog");

        run_frame(5, 8'h81, 8'h42, -1, 16'h0, "bad_header");
        run_frame(6, 8'h01, 8'h43, -1, 16'h0, "bad_cmd");

        // Snapshot must hold for the frame in progress
        ANALOG = 1'b0; BUTTONS = 16'hFFFF;
        run_frame(5, 8'h01, 8'h42, 1, 16'h0000, "snapshot");
        run_frame(5, 8'h01, 8'h42, -1, 16'h0, "snapshot_next");

        // Abort while ACK_N is low
        ack_seen = 0; fd_seen = 0;
        SPISS = 1'b0;
        #100;
        send_bits(8'h01, 8, got);
        #20;
        check("abort ack_low", ACK_N, 1'b0);
        skip_width = 1'b1;
        SPISS = 1'b1;
        #30;
        check("abort ack_release", ACK_N, 1'b1);
        check("abort sdo", SPISDO, 1'b1);
        #200;
        skip_width = 1'b0;

        // Abort after 4 bits of byte 2
        fd_seen = 0;
        SPISS = 1'b0;
        #100;
        send_bits(8'h01, 8, got); #240;
        send_bits(8'h42, 8, got); #240;
        send_bits(8'h00, 4, got);
        SPISS = 1'b1;
        #30;
        check("abort2 ack_n", ACK_N, 1'b1);
        check("abort2 sdo", SPISDO, 1'b1);
        #200;
        check("abort2 frame_done", fd_seen, 0);
        model_last_cmd = 8'h42;
        BUTTONS = 16'h5AA5;
        run_frame(5, 8'h01, 8'h42, -1, 16'h0, "after_abort");

        // Reset during byte 3
        SPISS = 1'b0;
        #100;
        send_bits(8'h01, 8, got); #240;
        send_bits(8'h42, 8, got); #240;
        send_bits(8'h00, 8, got); #240;
        send_bits(8'h00, 4, got);
        PRESET = 1'b1;
        #20;
        check_reset_outputs("mid_reset");
        model_last_cmd = 8'h00;
        SPISS = 1'b1;
        #50;
        PRESET = 1'b0;
        #100;
        ANALOG = 1'b1;
        run_frame(9, 8'h01, 8'h42, -1, 16'h0, "after_reset");

        // Randomized frames
        for (int f = 0; f < 10; f++) begin
            ANALOG  = 1'($urandom);
            BUTTONS = 16'($urandom);
            RX = 8'($urandom); RY = 8'($urandom); LX = 8'($urandom); LY = 8'($urandom);
            hdr = 8'h01;
            cmd = 8'h42;
            if ($urandom_range(0, 5) == 0) hdr = 8'($urandom_range(2, 255));
            else if ($urandom_range(0, 5) == 0) begin
                cmd = 8'($urandom_range(0, 255));
                if (cmd == 8'h42) cmd = 8'h43;
            end
            nb = (ANALOG ? 9 : 5) + int'($urandom_range(0, 1));
            run_frame(nb, hdr, cmd, -1, 16'h0, $sformatf("rand%0d", f));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
